// File: rtl/la_pkg.sv
// la_pkg: shared types and default sizes for the logic-analyzer capture path.
//   cap_state_t  - capture/dump sequencer states
//   SIM_*/DE0_*  - RAMqueue depth and address width for simulation and DE-0
package la_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CAPTURE = 3'd1,
    POST    = 3'd2,
    DONE    = 3'd3,
    DUMP    = 3'd4
  } cap_state_t;

  localparam int SIM_ENTRIES = 384;
  localparam int SIM_LOG2    = 9;
  localparam int DE0_ENTRIES = 12288;
  localparam int DE0_LOG2    = 14;

endpackage

// File: rtl/cap_addr_ctr.sv
// cap_addr_ctr: modulo-ENTRIES address counter for a RAMqueue port.
//   clk, rst_n  - core clock, async active-low reset
//   i_clr       - synchronous clear to 0 (highest priority)
//   i_load      - load i_load_val
//   i_inc       - advance by one, wrapping ENTRIES-1 -> 0
//   o_addr      - current address
module cap_addr_ctr
  import la_pkg::*;
#(
  parameter int ENTRIES = SIM_ENTRIES,
  parameter int LOG2    = SIM_LOG2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_clr,
  input  logic            i_load,
  input  logic [LOG2-1:0] i_load_val,
  input  logic            i_inc,
  output logic [LOG2-1:0] o_addr
);

  // Depth need not be a power of two, so the wrap is an explicit compare.
  localparam logic [LOG2-1:0] LAST = LOG2'(ENTRIES - 1);

  logic [LOG2-1:0] r_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= '0;
    end else if (i_clr) begin
      r_addr <= '0;
    end else if (i_load) begin
      r_addr <= i_load_val;
    end else if (i_inc) begin
      r_addr <= (r_addr == LAST) ? '0 : r_addr + LOG2'(1);
    end
  end

  assign o_addr = r_addr;

endmodule

// File: rtl/cap_ctrl.sv
// cap_ctrl: capture/dump sequencer for the five-channel RAMqueue buffers.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for run; write address and counters held at 0
// CAPTURE | pre-trigger fill; trigger accepted once armed
// POST    | counting out trig_pos post-trigger writes
// DONE    | buffer frozen, waddr points at the oldest entry
// DUMP    | replaying the buffer oldest-first via rd_vld/rd_ack
//
// Ports:
//   clk, rst_n    - core clock, async active-low reset (pre-synchronized)
//   wrt_smpl      - one-cycle strobe, decimated sample valid
//   run           - capture enable level; 0 aborts (ignored in DUMP)
//   triggered     - trigger condition level
//   trig_pos      - number of post-trigger samples, 0..ENTRIES-1
//   start_dump    - begin readout, honoured only in DONE
//   rd_ack        - consumer took the current read sample
//   we, waddr     - RAMqueue write enable / address
//   raddr         - RAMqueue read address
//   armed         - enough pre-trigger samples stored
//   rd_vld        - read data valid for current raddr
//   capture_done  - one-cycle pulse on entry to DONE
//   dump_done     - one-cycle pulse after the last sample is acked
module cap_ctrl
  import la_pkg::*;
#(
  parameter int ENTRIES = SIM_ENTRIES,
  parameter int LOG2    = SIM_LOG2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wrt_smpl,
  input  logic            run,
  input  logic            triggered,
  input  logic [LOG2-1:0] trig_pos,
  input  logic            start_dump,
  input  logic            rd_ack,
  output logic            we,
  output logic [LOG2-1:0] waddr,
  output logic [LOG2-1:0] raddr,
  output logic            armed,
  output logic            rd_vld,
  output logic            capture_done,
  output logic            dump_done
);

  localparam int            CW    = LOG2 + 1;
  localparam logic [CW-1:0] ENT_W = CW'(ENTRIES);

  cap_state_t r_state;
  cap_state_t w_state_nxt;

  logic [CW-1:0] r_smpl_cnt;
  logic [CW-1:0] r_post_cnt;
  logic [CW-1:0] r_rd_cnt;
  logic          r_armed;
  logic          r_rd_vld;
  logic          r_cap_done;
  logic          r_dump_done;

  logic          w_we;
  logic          w_ack;
  logic          w_post_last;
  logic          w_rd_last;
  logic          w_rload;
  logic [CW-1:0] w_arm_thr;
  logic [CW-1:0] w_trig_pos;
  logic [CW-1:0] w_post_nxt;
  logic [CW-1:0] w_rd_nxt;

  // Write lands in the same cycle as the strobe, so we stays combinational.
  assign w_we = wrt_smpl & ((r_state == CAPTURE) | (r_state == POST));

  assign w_trig_pos = {1'b0, trig_pos};
  assign w_arm_thr  = ENT_W - w_trig_pos;
  assign w_post_nxt = r_post_cnt + CW'(1);
  assign w_rd_nxt   = r_rd_cnt + CW'(1);

  // Only an ack against a valid sample consumes it.
  assign w_ack       = (r_state == DUMP) & r_rd_vld & rd_ack;
  assign w_post_last = w_we & (w_post_nxt == w_trig_pos);
  assign w_rd_last   = w_ack & (w_rd_nxt == ENT_W);
  assign w_rload     = (r_state == DONE) & start_dump;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (run) w_state_nxt = CAPTURE;
      end
      CAPTURE: begin
        if (!run)                       w_state_nxt = IDLE;
        else if (triggered && r_armed)  w_state_nxt = (trig_pos == '0) ? DONE : POST;
      end
      POST: begin
        // Abort takes precedence over the final post-trigger write.
        if (!run)             w_state_nxt = IDLE;
        else if (w_post_last) w_state_nxt = DONE;
      end
      DONE: begin
        // A dump request beats a simultaneous abort.
        if (start_dump) w_state_nxt = DUMP;
        else if (!run)  w_state_nxt = IDLE;
      end
      DUMP: begin
        if (w_rd_last) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_smpl_cnt  <= '0;
      r_post_cnt  <= '0;
      r_rd_cnt    <= '0;
      r_armed     <= 1'b0;
      r_rd_vld    <= 1'b0;
      r_cap_done  <= 1'b0;
      r_dump_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_armed     <= (r_state == CAPTURE) && (r_smpl_cnt >= w_arm_thr);
      r_cap_done  <= (w_state_nxt == DONE) && (r_state != DONE);
      r_dump_done <= w_rd_last;

      // Saturating at ENTRIES keeps the arm compare valid for long pre-fills.
      if (r_state == IDLE)
        r_smpl_cnt <= '0;
      else if ((r_state == CAPTURE) && w_we && (r_smpl_cnt != ENT_W))
        r_smpl_cnt <= r_smpl_cnt + CW'(1);

      // Held at zero until POST so the trigger transition needs no explicit clear.
      if ((r_state == IDLE) || (r_state == CAPTURE))
        r_post_cnt <= '0;
      else if ((r_state == POST) && w_we)
        r_post_cnt <= w_post_nxt;

      if (r_state == DONE)
        r_rd_cnt <= '0;
      else if (w_ack)
        r_rd_cnt <= w_rd_nxt;

      // One-cycle read latency: valid follows every load or advance by a cycle.
      if (r_state != DUMP)
        r_rd_vld <= 1'b0;
      else if (w_ack)
        r_rd_vld <= 1'b0;
      else
        r_rd_vld <= 1'b1;
    end
  end

  cap_addr_ctr #(
    .ENTRIES (ENTRIES),
    .LOG2    (LOG2)
  ) u_waddr (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr      (r_state == IDLE),
    .i_load     (1'b0),
    .i_load_val ('0),
    .i_inc      (w_we),
    .o_addr     (waddr)
  );

  // At DONE, waddr is the next slot to overwrite, i.e. the oldest sample.
  cap_addr_ctr #(
    .ENTRIES (ENTRIES),
    .LOG2    (LOG2)
  ) u_raddr (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr      (1'b0),
    .i_load     (w_rload),
    .i_load_val (waddr),
    .i_inc      (w_ack),
    .o_addr     (raddr)
  );

  assign we           = w_we;
  assign armed        = r_armed;
  assign rd_vld       = r_rd_vld;
  assign capture_done = r_cap_done;
  assign dump_done    = r_dump_done;

endmodule

// File: tb/tb_cap_ctrl.sv
module tb_cap_ctrl;

  localparam int E = 384;
  localparam int L = 9;

  localparam int M_IDLE = 0;
  localparam int M_CAP  = 1;
  localparam int M_POST = 2;
  localparam int M_DONE = 3;
  localparam int M_DUMP = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         wrt_smpl = 1'b0;
  logic         run = 1'b0;
  logic         triggered = 1'b0;
  logic [L-1:0] trig_pos = '0;
  logic         start_dump = 1'b0;
  logic         rd_ack = 1'b0;
  logic         we, armed, rd_vld, capture_done, dump_done;
  logic [L-1:0] waddr, raddr;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b1;

  always #5 clk = ~clk;

  cap_ctrl #(.ENTRIES(E), .LOG2(L)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wrt_smpl     (wrt_smpl),
    .run          (run),
    .triggered    (triggered),
    .trig_pos     (trig_pos),
    .start_dump   (start_dump),
    .rd_ack       (rd_ack),
    .we           (we),
    .waddr        (waddr),
    .raddr        (raddr),
    .armed        (armed),
    .rd_vld       (rd_vld),
    .capture_done (capture_done),
    .dump_done    (dump_done)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: tracks how many samples went in since the run began,
  // how many pre/post-trigger samples there were, and how many were read out.
  // Addresses follow as plain modulo arithmetic on those counts.
  int m_mode = M_IDLE;
  int m_wr = 0, m_pre = 0, m_post = 0, m_dstart = 0, m_acks = 0;
  bit m_armed = 0, m_vld = 0, m_cd = 0, m_dd = 0;
  int old_mode;
  bit wr_now, nx_armed;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = M_IDLE; m_wr = 0; m_pre = 0; m_post = 0; m_dstart = 0; m_acks = 0;
      m_armed = 0; m_vld = 0; m_cd = 0; m_dd = 0;
    end else begin
      old_mode = m_mode;
      wr_now   = wrt_smpl && (m_mode == M_CAP || m_mode == M_POST);
      nx_armed = (m_mode == M_CAP) && (m_pre >= E - int'(trig_pos));
      m_cd = 0;
      m_dd = 0;
      if (m_mode != M_DUMP) m_vld = 0;
      case (m_mode)
        M_IDLE: begin
          m_wr = 0; m_pre = 0; m_post = 0;
          if (run) m_mode = M_CAP;
        end
        M_CAP: begin
          if (!run) m_mode = M_IDLE;
          else if (triggered && m_armed) begin
            if (trig_pos == 0) begin m_mode = M_DONE; m_cd = 1; end
            else m_mode = M_POST;
          end
        end
        M_POST: begin
          if (!run) m_mode = M_IDLE;
          else if (wr_now && (m_post + 1 == int'(trig_pos))) begin m_mode = M_DONE; m_cd = 1; end
        end
        M_DONE: begin
          if (start_dump) begin m_mode = M_DUMP; m_dstart = m_wr % E; m_acks = 0; m_vld = 0; end
          else if (!run) m_mode = M_IDLE;
        end
        M_DUMP: begin
          if (m_vld && rd_ack) begin
            m_acks++;
            m_vld = 0;
            if (m_acks == E) begin m_dd = 1; m_mode = M_IDLE; end
          end else m_vld = 1;
        end
        default: m_mode = M_IDLE;
      endcase
      if (wr_now) begin
        m_wr++;
        if (old_mode == M_CAP)  m_pre++;
        if (old_mode == M_POST) m_post++;
      end
      m_armed = nx_armed;
    end
  end

  // Compare process plus event counters (writes, pulses, first armed point).
  int n_we = 0, n_cd = 0, n_dd = 0, arm_at = -1;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("we",           int'(we),           int'(wrt_smpl && (m_mode == M_CAP || m_mode == M_POST)));
      chk("waddr",        int'(waddr),        m_wr % E);
      chk("raddr",        int'(raddr),        (m_dstart + m_acks) % E);
      chk("armed",        int'(armed),        int'(m_armed));
      chk("rd_vld",       int'(rd_vld),       int'(m_vld));
      chk("capture_done", int'(capture_done), int'(m_cd));
      chk("dump_done",    int'(dump_done),    int'(m_dd));
    end
    if (we) n_we++;
    if (capture_done) n_cd++;
    if (dump_done) n_dd++;
    if (armed && arm_at < 0) arm_at = n_we;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int gap, input bit trig_pulse);
    wrt_smpl = 1'b1;
    if (trig_pulse) triggered = 1'b1;
    tick();
    wrt_smpl = 1'b0;
    if (trig_pulse) triggered = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic wait_vld();
    int w;
    w = 0;
    while (!rd_vld && w < 10) begin tick(); w++; end
    chk("rd_vld_wait", int'(rd_vld), 1);
  endtask

  int b_we, b_cd, b_dd, guard;

  initial begin
    repeat (3) tick();
    chk("rst_waddr", int'(waddr), 0);
    chk("rst_raddr", int'(raddr), 0);
    chk("rst_flags", int'({we, armed, rd_vld, capture_done, dump_done}), 0);
    rst_n = 1'b1;
    tick();

    // 1: trig_pos=100, trigger held high from the start, strobe every 4 clocks
    trig_pos = 9'd100; triggered = 1'b1; run = 1'b1;
    repeat (2) tick();
    guard = 0;
    while (n_cd == 0 && guard < 600) begin wr(3, 1'b0); guard++; end
    chk("arm_after_write", arm_at, 284);
    chk("s1_total_writes", n_we, 384);
    chk("s1_done_waddr", int'(waddr), 0);
    repeat (3) wr(3, 1'b0);
    chk("s1_we_after_done", n_we, 384);
    chk("s1_cd_pulses", n_cd, 1);

    // 2: 1000 writes, single trigger pulse on write #900, then full dump
    triggered = 1'b0; run = 1'b0;
    repeat (2) tick();
    b_we = n_we; b_cd = n_cd; b_dd = n_dd;
    run = 1'b1;
    repeat (2) tick();
    repeat (899) wr(3, 1'b0);
    wr(3, 1'b1);
    repeat (100) wr(3, 1'b0);
    chk("s2_writes", n_we - b_we, 1000);
    chk("s2_cd_pulses", n_cd - b_cd, 1);
    chk("s2_done_waddr", int'(waddr), 232);
    start_dump = 1'b1; run = 1'b0;
    tick();
    start_dump = 1'b0;
    chk("dump_first_raddr", int'(raddr), 232);
    chk("dump_vld_lat0", int'(rd_vld), 0);
    tick();
    chk("dump_vld_lat1", int'(rd_vld), 1);
    for (int k = 0; k < E; k++) begin
      wait_vld();
      repeat (3) tick();
      chk("dump_raddr_seq", int'(raddr), (232 + k) % E);
      rd_ack = 1'b1;
      tick();
      if (k % 64 == 0) tick();
      rd_ack = 1'b0;
    end
    repeat (2) tick();
    chk("s2_dd_pulses", n_dd - b_dd, 1);
    chk("s2_idle_vld", int'(rd_vld), 0);
    chk("s2_end_raddr", int'(raddr), 232);

    // 3: trig_pos=0, trigger on write #400 -> DONE with no post writes
    trig_pos = '0;
    b_we = n_we; b_cd = n_cd;
    run = 1'b1;
    repeat (2) tick();
    repeat (399) wr(1, 1'b0);
    wr(1, 1'b1);
    tick();
    chk("s3_cd_pulses", n_cd - b_cd, 1);
    chk("s3_done_waddr", int'(waddr), 16);
    repeat (2) wr(1, 1'b0);
    chk("s3_no_post_writes", n_we - b_we, 400);

    // 4: abort in the same cycle as the final post-trigger write
    run = 1'b0;
    repeat (2) tick();
    trig_pos = 9'd100; triggered = 1'b1;
    b_we = n_we; b_cd = n_cd;
    run = 1'b1;
    repeat (2) tick();
    repeat (383) wr(3, 1'b0);
    run = 1'b0;
    wr(3, 1'b0);
    tick();
    chk("s4_writes", n_we - b_we, 384);
    chk("s4_no_cd", n_cd - b_cd, 0);
    triggered = 1'b0; run = 1'b1;
    repeat (2) tick();
    chk("s4_restart_waddr", int'(waddr), 0);
    chk("s4_restart_armed", int'(armed), 0);

    // 5: async reset in the middle of a dump
    run = 1'b0;
    repeat (2) tick();
    trig_pos = 9'd383; triggered = 1'b1;
    b_cd = n_cd;
    run = 1'b1;
    repeat (2) tick();
    guard = 0;
    while (n_cd == b_cd && guard < 800) begin wr(0, 1'b0); guard++; end
    chk("s5_cd_pulses", n_cd - b_cd, 1);
    triggered = 1'b0;
    start_dump = 1'b1; run = 1'b0;
    tick();
    start_dump = 1'b0;
    repeat (5) begin
      wait_vld();
      rd_ack = 1'b1;
      tick();
      rd_ack = 1'b0;
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("s5_rst_raddr", int'(raddr), 0);
    chk("s5_rst_waddr", int'(waddr), 0);
    chk("s5_rst_flags", int'({we, armed, rd_vld, capture_done, dump_done}), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    start_dump = 1'b1;
    tick();
    start_dump = 1'b0;
    repeat (3) begin
      chk("s5_ignore_dump_vld", int'(rd_vld), 0);
      chk("s5_ignore_dump_raddr", int'(raddr), 0);
      tick();
    end

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
